// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the management-port Wishbone bridge.
// Holds the FSM encoding, the downstream request record, and the status register layout.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCAL,
        REQ,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    localparam logic [31:0] LOCAL_ADDR = 32'h3080_0000;
    localparam logic [31:0] ERR_DATA   = 32'hDEAD_DEAD;
    localparam logic [7:0]  BANK_RST   = 8'h10;

    localparam int TO_BIT  = 16;
    localparam int ERR_BIT = 17;

    function automatic logic [31:0] status_word(input logic [7:0] bank,
                                                input logic       to_flag,
                                                input logic       err_flag);
        logic [31:0] w;
        w          = '0;
        w[7:0]     = bank;
        w[TO_BIT]  = to_flag;
        w[ERR_BIT] = err_flag;
        return w;
    endfunction

endpackage

// File: rtl/wb_bridge_tocnt.sv
// Purpose: counts cycles a forwarded request has been outstanding; flags the last allowed cycle.
// Latency: expire is combinational from the count, asserted on the TIMEOUT-th enabled cycle.
// Backpressure: none; clr has priority over en and returns the count to zero on the next edge.
module wb_bridge_tocnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/wb_ext_bridge.sv
// Purpose: re-issues management-SoC Wishbone transfers onto the internal bus with a banked top byte.
// Latency: local register ack 2 cycles after stb; forwarded ack 1 cycle after downstream ack/err/timeout.
// Backpressure: one transfer in flight; the requester waits on wbd_ext_ack_o, downstream waits on m_ack_i.
module wb_ext_bridge #(
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] LOCAL_ADDR = wb_bridge_pkg::LOCAL_ADDR,
    parameter logic [7:0]  BANK_RST   = wb_bridge_pkg::BANK_RST,
    parameter logic [31:0] ERR_DATA   = wb_bridge_pkg::ERR_DATA
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbd_ext_cyc_i,
    input  logic        wbd_ext_stb_i,
    input  logic        wbd_ext_we_i,
    input  logic [3:0]  wbd_ext_sel_i,
    input  logic [31:0] wbd_ext_adr_i,
    input  logic [31:0] wbd_ext_dat_i,
    output logic        wbd_ext_ack_o,
    output logic [31:0] wbd_ext_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        bridge_err_o
);

    import wb_bridge_pkg::*;

    state_t  state;
    wb_req_t m_req_q;
    logic    [7:0] bank;
    logic    to_flag;
    logic    err_flag;

    logic ext_req;
    logic req_done;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_exp;

    assign ext_req  = wbd_ext_cyc_i && wbd_ext_stb_i;
    assign req_done = (state == REQ) &&
                      (!wbd_ext_cyc_i || m_ack_i || m_err_i || cnt_exp);
    assign cnt_en   = (state == REQ);
    assign cnt_clr  = (state != REQ) || req_done;

    wb_bridge_tocnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tocnt (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expire  (cnt_exp)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            m_req_q       <= '0;
            m_cyc_o       <= 1'b0;
            m_stb_o       <= 1'b0;
            wbd_ext_ack_o <= 1'b0;
            wbd_ext_dat_o <= '0;
            bank          <= BANK_RST;
            to_flag       <= 1'b0;
            err_flag      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ext_req && (wbd_ext_adr_i == LOCAL_ADDR)) begin
                        state <= LOCAL;
                    end else if (ext_req) begin
                        state   <= REQ;
                        m_cyc_o <= 1'b1;
                        m_stb_o <= 1'b1;
                        m_req_q <= '{we:  wbd_ext_we_i,
                                     sel: wbd_ext_sel_i,
                                     adr: {bank, wbd_ext_adr_i[23:0]},
                                     dat: wbd_ext_dat_i};
                    end
                end

                // The requester holds its bus until ack, so the live inputs are used here.
                // Flags are only set in REQ, so a clear can never race a new event.
                LOCAL: begin
                    if (wbd_ext_we_i) begin
                        if (wbd_ext_sel_i[0]) begin
                            bank <= wbd_ext_dat_i[7:0];
                        end
                        if (wbd_ext_sel_i[2] && wbd_ext_dat_i[TO_BIT]) begin
                            to_flag <= 1'b0;
                        end
                        if (wbd_ext_sel_i[2] && wbd_ext_dat_i[ERR_BIT]) begin
                            err_flag <= 1'b0;
                        end
                        wbd_ext_dat_o <= '0;
                    end else begin
                        wbd_ext_dat_o <= status_word(bank, to_flag, err_flag);
                    end
                    wbd_ext_ack_o <= 1'b1;
                    state         <= RESP;
                end

                REQ: begin
                    if (req_done) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                    end
                    if (!wbd_ext_cyc_i) begin
                        state <= IDLE;
                    end else if (m_ack_i) begin
                        wbd_ext_dat_o <= m_req_q.we ? 32'h0 : m_dat_i;
                        wbd_ext_ack_o <= 1'b1;
                        state         <= RESP;
                    end else if (m_err_i) begin
                        wbd_ext_dat_o <= m_req_q.we ? 32'h0 : ERR_DATA;
                        wbd_ext_ack_o <= 1'b1;
                        err_flag      <= 1'b1;
                        state         <= RESP;
                    end else if (cnt_exp) begin
                        wbd_ext_dat_o <= m_req_q.we ? 32'h0 : ERR_DATA;
                        wbd_ext_ack_o <= 1'b1;
                        to_flag       <= 1'b1;
                        state         <= RESP;
                    end
                end

                RESP: begin
                    wbd_ext_ack_o <= 1'b0;
                    wbd_ext_dat_o <= '0;
                    state         <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign m_we_o       = m_req_q.we;
    assign m_sel_o      = m_req_q.sel;
    assign m_adr_o      = m_req_q.adr;
    assign m_dat_o      = m_req_q.dat;
    assign bridge_err_o = to_flag || err_flag;

endmodule

// File: tb/tb_wb_ext_bridge.sv
// Directed bench for wb_ext_bridge: forwarded and local transfers, timeout, errors, abort, reset.
module tb_wb_ext_bridge;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbd_ext_cyc_i;
    logic        wbd_ext_stb_i;
    logic        wbd_ext_we_i;
    logic [3:0]  wbd_ext_sel_i;
    logic [31:0] wbd_ext_adr_i;
    logic [31:0] wbd_ext_dat_i;
    logic        wbd_ext_ack_o;
    logic [31:0] wbd_ext_dat_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i;
    logic        m_err_i;
    logic        bridge_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_ext_bridge dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .wbd_ext_cyc_i (wbd_ext_cyc_i),
        .wbd_ext_stb_i (wbd_ext_stb_i),
        .wbd_ext_we_i  (wbd_ext_we_i),
        .wbd_ext_sel_i (wbd_ext_sel_i),
        .wbd_ext_adr_i (wbd_ext_adr_i),
        .wbd_ext_dat_i (wbd_ext_dat_i),
        .wbd_ext_ack_o (wbd_ext_ack_o),
        .wbd_ext_dat_o (wbd_ext_dat_o),
        .m_cyc_o       (m_cyc_o),
        .m_stb_o       (m_stb_o),
        .m_we_o        (m_we_o),
        .m_sel_o       (m_sel_o),
        .m_adr_o       (m_adr_o),
        .m_dat_o       (m_dat_o),
        .m_dat_i       (m_dat_i),
        .m_ack_i       (m_ack_i),
        .m_err_i       (m_err_i),
        .bridge_err_o  (bridge_err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    // One requester transfer with a scripted slave that answers in REQ cycle resp_cyc (0 = never).
    task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] wdat,
                        input int resp_cyc, input logic s_ack, input logic s_err,
                        input logic [31:0] s_dat,
                        output logic [31:0] rdat, output int lat, output logic m_seen,
                        output logic [31:0] m_adr_s, output logic m_we_s,
                        output logic [31:0] m_dat_s);
        int nreq;
        nreq    = 0;
        lat     = 0;
        rdat    = 'x;
        m_seen  = 1'b0;
        m_adr_s = 'x;
        m_we_s  = 1'bx;
        m_dat_s = 'x;
        wbd_ext_cyc_i = 1'b1;
        wbd_ext_stb_i = 1'b1;
        wbd_ext_we_i  = we;
        wbd_ext_sel_i = sel;
        wbd_ext_adr_i = adr;
        wbd_ext_dat_i = wdat;
        for (int i = 1; i <= 400; i++) begin
            step();
            m_ack_i = 1'b0;
            m_err_i = 1'b0;
            if (wbd_ext_ack_o) begin
                lat  = i;
                rdat = wbd_ext_dat_o;
                chk({tag, "_mcyc_at_ack"}, {31'b0, m_cyc_o}, 32'd0);
                break;
            end
            if (m_cyc_o) begin
                if (!m_seen) begin
                    m_seen  = 1'b1;
                    m_adr_s = m_adr_o;
                    m_we_s  = m_we_o;
                    m_dat_s = m_dat_o;
                end
                nreq++;
                if (nreq == resp_cyc) begin
                    m_ack_i = s_ack;
                    m_err_i = s_err;
                    m_dat_i = s_dat;
                end
            end
        end
        step();
        chk({tag, "_ack_single"}, {31'b0, wbd_ext_ack_o}, 32'd0);
        wbd_ext_cyc_i = 1'b0;
        wbd_ext_stb_i = 1'b0;
        step();
    endtask

    logic [31:0] rd;
    int          lat;
    logic        seen;
    logic [31:0] madr;
    logic        mwe;
    logic [31:0] mdat;
    logic        ack_any;

    initial begin
        wb_rst_i      = 1'b1;
        wbd_ext_cyc_i = 1'b0;
        wbd_ext_stb_i = 1'b0;
        wbd_ext_we_i  = 1'b0;
        wbd_ext_sel_i = 4'h0;
        wbd_ext_adr_i = 32'h0;
        wbd_ext_dat_i = 32'h0;
        m_dat_i       = 32'h0;
        m_ack_i       = 1'b0;
        m_err_i       = 1'b0;
        repeat (3) step();

        chk("rst_m_cyc", {31'b0, m_cyc_o}, 32'd0);
        chk("rst_m_stb", {31'b0, m_stb_o}, 32'd0);
        chk("rst_m_we",  {31'b0, m_we_o}, 32'd0);
        chk("rst_m_sel", {28'b0, m_sel_o}, 32'd0);
        chk("rst_m_adr", m_adr_o, 32'd0);
        chk("rst_m_dat", m_dat_o, 32'd0);
        chk("rst_ack",   {31'b0, wbd_ext_ack_o}, 32'd0);
        chk("rst_dat",   wbd_ext_dat_o, 32'd0);
        chk("rst_err",   {31'b0, bridge_err_o}, 32'd0);
        wb_rst_i = 1'b0;
        step();

        // Forwarded read, slave answers in the 3rd REQ cycle.
        xfer("fwd_rd", 1'b0, 32'h3000_0040, 4'hF, 32'h0, 3, 1'b1, 1'b0, 32'h1234_5678,
             rd, lat, seen, madr, mwe, mdat);
        chk("fwd_rd_adr",  madr, 32'h1000_0040);
        chk("fwd_rd_we",   {31'b0, mwe}, 32'd0);
        chk("fwd_rd_dat",  rd, 32'h1234_5678);
        chk("fwd_rd_lat",  lat, 32'd4);

        // Bank write is local only.
        xfer("bank_wr", 1'b1, 32'h3080_0000, 4'b0001, 32'h0000_0022, 0, 1'b0, 1'b0, 32'h0,
             rd, lat, seen, madr, mwe, mdat);
        chk("bank_wr_mseen", {31'b0, seen}, 32'd0);
        chk("bank_wr_lat",   lat, 32'd2);
        chk("bank_wr_dat",   rd, 32'd0);

        xfer("fwd_wr", 1'b1, 32'h3000_0100, 4'hF, 32'hA5A5_A5A5, 1, 1'b1, 1'b0, 32'hFFFF_FFFF,
             rd, lat, seen, madr, mwe, mdat);
        chk("fwd_wr_adr", madr, 32'h2200_0100);
        chk("fwd_wr_we",  {31'b0, mwe}, 32'd1);
        chk("fwd_wr_mdat", mdat, 32'hA5A5_A5A5);
        chk("fwd_wr_rdat", rd, 32'd0);
        chk("fwd_wr_lat",  lat, 32'd2);

        xfer("stat0", 1'b0, 32'h3080_0000, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0,
             rd, lat, seen, madr, mwe, mdat);
        chk("stat0_val",   rd, 32'h0000_0022);
        chk("stat0_mseen", {31'b0, seen}, 32'd0);

        // Timeout: the slave never answers.
        xfer("tmo", 1'b0, 32'h3000_0000, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0,
             rd, lat, seen, madr, mwe, mdat);
        chk("tmo_adr", madr, 32'h2200_0000);
        chk("tmo_lat", lat, 32'd256);
        chk("tmo_dat", rd, 32'hDEAD_DEAD);
        chk("tmo_berr", {31'b0, bridge_err_o}, 32'd1);

        xfer("stat1", 1'b0, 32'h3080_0000, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0,
             rd, lat, seen, madr, mwe, mdat);
        chk("stat1_val", rd, 32'h0001_0022);

        // Downstream error.
        xfer("err", 1'b0, 32'h3000_0008, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'h1111_1111,
             rd, lat, seen, madr, mwe, mdat);
        chk("err_dat", rd, 32'hDEAD_DEAD);
        chk("err_lat", lat, 32'd3);

        xfer("stat2", 1'b0, 32'h3080_0000, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0,
             rd, lat, seen, madr, mwe, mdat);
        chk("stat2_val", rd, 32'h0003_0022);

        xfer("clr", 1'b1, 32'h3080_0000, 4'b0100, 32'h0003_0000, 0, 1'b0, 1'b0, 32'h0,
             rd, lat, seen, madr, mwe, mdat);
        chk("clr_berr", {31'b0, bridge_err_o}, 32'd0);

        xfer("stat3", 1'b0, 32'h3080_0000, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0,
             rd, lat, seen, madr, mwe, mdat);
        chk("stat3_val", rd, 32'h0000_0022);

        // Ack and err together: ack wins.
        xfer("ackerr", 1'b0, 32'h3000_000C, 4'hF, 32'h0, 1, 1'b1, 1'b1, 32'hCAFE_F00D,
             rd, lat, seen, madr, mwe, mdat);
        chk("ackerr_dat",  rd, 32'hCAFE_F00D);
        chk("ackerr_berr", {31'b0, bridge_err_o}, 32'd0);

        // Master abort in REQ.
        wbd_ext_cyc_i = 1'b1;
        wbd_ext_stb_i = 1'b1;
        wbd_ext_we_i  = 1'b0;
        wbd_ext_sel_i = 4'hF;
        wbd_ext_adr_i = 32'h3000_0010;
        step();
        chk("abort_mcyc_up", {31'b0, m_cyc_o}, 32'd1);
        step();
        step();
        wbd_ext_cyc_i = 1'b0;
        wbd_ext_stb_i = 1'b0;
        step();
        chk("abort_mcyc_dn", {31'b0, m_cyc_o}, 32'd0);
        chk("abort_mstb_dn", {31'b0, m_stb_o}, 32'd0);
        ack_any = wbd_ext_ack_o;
        for (int i = 0; i < 4; i++) begin
            step();
            ack_any = ack_any | wbd_ext_ack_o;
        end
        chk("abort_no_ack", {31'b0, ack_any}, 32'd0);

        xfer("post_abort", 1'b0, 32'h3000_0014, 4'hF, 32'h0, 1, 1'b1, 1'b0, 32'h0BAD_BEEF,
             rd, lat, seen, madr, mwe, mdat);
        chk("post_abort_dat", rd, 32'h0BAD_BEEF);
        chk("post_abort_lat", lat, 32'd2);

        // Reset in the 5th REQ cycle.
        wbd_ext_cyc_i = 1'b1;
        wbd_ext_stb_i = 1'b1;
        wbd_ext_we_i  = 1'b0;
        wbd_ext_adr_i = 32'h3000_0020;
        repeat (5) step();
        chk("rstreq_mcyc_up", {31'b0, m_cyc_o}, 32'd1);
        wb_rst_i = 1'b1;
        step();
        chk("rstreq_mcyc", {31'b0, m_cyc_o}, 32'd0);
        chk("rstreq_ack",  {31'b0, wbd_ext_ack_o}, 32'd0);
        wb_rst_i      = 1'b0;
        wbd_ext_cyc_i = 1'b0;
        wbd_ext_stb_i = 1'b0;
        step();
        chk("rstreq_ack2", {31'b0, wbd_ext_ack_o}, 32'd0);

        xfer("stat4", 1'b0, 32'h3080_0000, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0,
             rd, lat, seen, madr, mwe, mdat);
        chk("stat4_val", rd, 32'h0000_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
